// File: rtl/proc_zbt_writer.sv
// Buffers processed pixel pairs in a small FIFO and writes them to ZBT bank 1 in bus idle cycles.
// Optional macro PROC_ZBT_WRITER_STATS_EN adds a per-frame write count output (pairs_written).
module proc_zbt_writer #(
    parameter int unsigned DEPTH_LOG = 3,
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned ZBT_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic [35:0]          two_proc_pixs,
    input  logic [18:0]          proc_pix_addr,
    input  logic                 rd_req,
    input  logic [18:0]          rd_addr,
    output logic [18:0]          vram_addr,
    output logic                 vram_we,
    output logic [35:0]          vram_write_data,
    output logic [DEPTH_LOG:0]   fifo_level,
    output logic                 overflow
`ifdef PROC_ZBT_WRITER_STATS_EN
    ,
    output logic [19:0]          pairs_written
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam logic [10:0] HMAX = 11'(H_ACTIVE);
    localparam logic [9:0]  VMAX = 10'(V_ACTIVE);
    localparam logic [DEPTH_LOG:0] FULL_LVL = (DEPTH_LOG + 1)'(DEPTH);

    logic [18:0] addr_mem [DEPTH];
    logic [35:0] data_mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;

    logic [35:0]        pipe_data [ZBT_LAT];
    logic [ZBT_LAT-1:0] pipe_vld;

    logic capture, frame_start, fifo_full, pop, push, drop;

    always_comb begin
        capture     = ~hcount[0] && (hcount < HMAX) && (vcount < VMAX);
        frame_start = (hcount == 11'd0) && (vcount == 10'd0);
        fifo_full   = (fifo_level == FULL_LVL);
        // Pop uses the registered level, so a fresh entry never falls through.
        pop         = ~rd_req && (fifo_level != '0);
        push        = capture && (~fifo_full || pop);
        drop        = capture && fifo_full && ~pop;
    end

    // Storage needs no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= proc_pix_addr;
            data_mem[wr_ptr] <= two_proc_pixs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_level      <= '0;
            overflow        <= 1'b0;
            vram_addr       <= '0;
            vram_we         <= 1'b0;
            vram_write_data <= '0;
            pipe_vld        <= '0;
            for (int i = 0; i < ZBT_LAT; i++) pipe_data[i] <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            if (frame_start)  overflow <= drop;
            else if (drop)    overflow <= 1'b1;

            vram_we <= pop;
            if (rd_req)   vram_addr <= rd_addr;
            else if (pop) vram_addr <= addr_mem[rd_ptr];

            // Stage 0 is visible alongside vram_we; the output register adds the last cycle.
            pipe_vld[0]  <= pop;
            pipe_data[0] <= data_mem[rd_ptr];
            for (int i = 1; i < ZBT_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            if (pipe_vld[ZBT_LAT-1]) vram_write_data <= pipe_data[ZBT_LAT-1];
        end
    end

`ifdef PROC_ZBT_WRITER_STATS_EN
    logic [19:0] wr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt        <= '0;
            pairs_written <= '0;
        end else if (frame_start) begin
            pairs_written <= wr_cnt;
            wr_cnt        <= {19'd0, pop};
        end else begin
            wr_cnt        <= wr_cnt + {19'd0, pop};
        end
    end
`endif

endmodule

// File: tb/tb_proc_zbt_writer.sv
// Directed self-checking bench for proc_zbt_writer (default parameters).
module tb_proc_zbt_writer;

    logic        clk;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [35:0] two_proc_pixs;
    logic [18:0] proc_pix_addr;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic [18:0] vram_addr;
    logic        vram_we;
    logic [35:0] vram_write_data;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef PROC_ZBT_WRITER_STATS_EN
    logic [19:0] pairs_written;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    proc_zbt_writer dut (
        .clk             (clk),
        .reset           (reset),
        .hcount          (hcount),
        .vcount          (vcount),
        .two_proc_pixs   (two_proc_pixs),
        .proc_pix_addr   (proc_pix_addr),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .vram_addr       (vram_addr),
        .vram_we         (vram_we),
        .vram_write_data (vram_write_data),
        .fifo_level      (fifo_level),
        .overflow        (overflow)
`ifdef PROC_ZBT_WRITER_STATS_EN
        ,
        .pairs_written   (pairs_written)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int writes;
    int max_lvl;

    initial begin
        reset = 1'b1; hcount = 11'd1025; vcount = 10'd5; two_proc_pixs = '0;
        proc_pix_addr = '0; rd_req = 1'b0; rd_addr = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_we", 64'(vram_we), 64'd0);
        check("rst_addr", 64'(vram_addr), 64'd0);
        check("rst_wdata", 64'(vram_write_data), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        // Reset mid-frame with 5 buffered and one write in flight
        rd_req = 1'b1; rd_addr = 19'h7ABCD;
        for (int i = 0; i < 5; i++) begin
            hcount = 11'(10 + 2 * i); proc_pix_addr = 19'(16'h4000 + i);
            two_proc_pixs = 36'(36'h0BEEF0000 + i);
            step();
        end
        check("fill5_level", 64'(fifo_level), 64'd5);
        rd_req = 1'b0; hcount = 11'd1025;
        step();
        check("fill5_pop_we", 64'(vram_we), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_level", 64'(fifo_level), 64'd0);
        check("midrst_we", 64'(vram_we), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_idle_we", 64'(vram_we), 64'd0);
            check("midrst_idle_wdata", 64'(vram_write_data), 64'd0);
        end

        // Single capture and write-data latency
        hcount = 11'd4; vcount = 10'd5; proc_pix_addr = 19'h00102;
        two_proc_pixs = 36'h123456789;
        step();
        check("single_level", 64'(fifo_level), 64'd1);
        check("single_nofall_we", 64'(vram_we), 64'd0);
        hcount = 11'd5;
        step();
        check("single_we", 64'(vram_we), 64'd1);
        check("single_addr", 64'(vram_addr), 64'h00102);
        check("single_level0", 64'(fifo_level), 64'd0);
        step();
        check("single_we_low", 64'(vram_we), 64'd0);
        check("single_addr_hold", 64'(vram_addr), 64'h00102);
        check("single_wdata_early", 64'(vram_write_data), 64'd0);
        step();
        check("single_wdata", 64'(vram_write_data), 64'h123456789);
        hcount = 11'd7;
        step();
        check("single_wdata_hold", 64'(vram_write_data), 64'h123456789);

        // Overflow: 10 captures while reads hold the bus
        do_reset();
        rd_req = 1'b1; rd_addr = 19'h7ABCD; vcount = 10'd5;
        for (int i = 0; i < 20; i++) begin
            hcount = 11'(10 + i); proc_pix_addr = 19'(16'h1000 + i);
            two_proc_pixs = 36'h A00000000 | 36'(i);
            step();
        end
        check("ovf_level", 64'(fifo_level), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_rd_addr", 64'(vram_addr), 64'h7ABCD);
        check("ovf_rd_we", 64'(vram_we), 64'd0);
        rd_req = 1'b0; hcount = 11'd1025;
        for (int j = 0; j < 10; j++) begin
            step();
            if (j < 8) begin
                check("ovf_drain_we", 64'(vram_we), 64'd1);
                check("ovf_drain_addr", 64'(vram_addr), 64'(16'h1000 + 2 * j));
            end
            if (j >= 2)
                check("ovf_drain_wdata", 64'(vram_write_data),
                      64'(36'hA00000000 | 36'(2 * (j - 2))));
        end
        check("ovf_empty", 64'(fifo_level), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        hcount = 11'd0; vcount = 10'd0;
        step();
        check("ovf_frame_clear", 64'(overflow), 64'd0);
        check("ovf_frame_capture", 64'(fifo_level), 64'd1);

        // Full FIFO with pop and push in the same cycle
        do_reset();
        rd_req = 1'b1; vcount = 10'd1;
        for (int i = 0; i < 8; i++) begin
            hcount = 11'(2 * i); proc_pix_addr = 19'(16'h3000 + i);
            two_proc_pixs = 36'(i);
            step();
        end
        check("full_level", 64'(fifo_level), 64'd8);
        rd_req = 1'b0; hcount = 11'd100; proc_pix_addr = 19'h03008;
        step();
        check("full_pp_level", 64'(fifo_level), 64'd8);
        check("full_pp_ovf", 64'(overflow), 64'd0);
        check("full_pp_we", 64'(vram_we), 64'd1);
        check("full_pp_addr", 64'(vram_addr), 64'h03000);
        hcount = 11'd1025;
        for (int j = 1; j <= 8; j++) begin
            step();
            check("full_drain_we", 64'(vram_we), 64'd1);
            check("full_drain_addr", 64'(vram_addr), 64'(16'h3000 + j));
        end
        step();
        check("full_drain_done_we", 64'(vram_we), 64'd0);
        check("full_drain_level", 64'(fifo_level), 64'd0);

        // Alternating reads across a full active line
        do_reset();
        vcount = 10'd3; rd_addr = 19'h7FFFF;
        writes = 0; max_lvl = 0;
        for (int h = 0; h < 1027; h++) begin
            hcount = 11'(h); rd_req = (h % 2 == 1) && (h < 1024);
            proc_pix_addr = 19'(32'h20000 + h); two_proc_pixs = 36'(h);
            step();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (vram_we) begin
                check("alt_addr", 64'(vram_addr), 64'(32'h20000 + 2 * writes));
                writes++;
            end
        end
        check("alt_writes", 64'(writes), 64'd512);
        check("alt_max_level", 64'(max_lvl), 64'd1);
        hcount = 11'd0; vcount = 10'd0; rd_req = 1'b1;
        step();
        check("alt_frame_ovf", 64'(overflow), 64'd0);
`ifdef PROC_ZBT_WRITER_STATS_EN
        check("stats_pairs_written", 64'(pairs_written), 64'd512);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_zbt_writer.md
Name: proc_zbt_writer

Overview:
- Downstream neighbour of the colour-processing stage. Captures each processed pixel pair and its ZBT word address, buffers them in a small FIFO, and issues writes to ZBT bank 1.
- Writes are issued in bus cycles not claimed by the display read path.
- Models the ZBT write pipeline: write data is driven ZBT_LAT cycles after the address/WE cycle.

Parameters:
- DEPTH_LOG, 3, log2 of FIFO depth (8 entries of 55 bits: 19 addr + 36 data).
- H_ACTIVE, 1024, pairs are captured only while hcount < H_ACTIVE.
- V_ACTIVE, 768, pairs are captured only while vcount < V_ACTIVE.
- ZBT_LAT, 2, cycles from write address/WE to write data on the bus.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- hcount  input  11  current horizontal count.
- vcount  input  10  current vertical count.
- two_proc_pixs  input  36  processed pixel pair ({pix0[35:18], pix1[17:0]}).
- proc_pix_addr  input  19  ZBT word address for two_proc_pixs.
- rd_req  input  1  display path claims the bus this cycle.
- rd_addr  input  19  display read address.
- vram_addr  output  19  ZBT bank 1 address.
- vram_we  output  1  ZBT write enable, active-high, asserted with the address.
- vram_write_data  output  36  ZBT write data, valid ZBT_LAT cycles after the vram_we cycle.
- fifo_level  output  DEPTH_LOG+1  current FIFO occupancy.
- overflow  output  1  sticky: a capture was dropped since the last frame start.

Behaviour:
- Reset, synchronous: FIFO emptied, fifo_level=0, overflow=0, vram_we=0, vram_addr=0, vram_write_data=0, write-data delay pipe cleared.
  - Reset mid-frame discards all buffered entries and all writes in flight.
  - The first capture after reset deasserts waits for the next qualifying cycle.
- Capture (push): on a cycle with hcount[0]==0 && hcount<H_ACTIVE && vcount<V_ACTIVE, push {proc_pix_addr, two_proc_pixs}. Inputs are sampled on that cycle only.
- Bus arbitration, decided combinationally each cycle, registered outputs:
  - rd_req=1: vram_addr<=rd_addr, vram_we<=0. Reads always win.
  - rd_req=0 and FIFO non-empty: pop head, vram_addr<=head.addr, vram_we<=1, head.data enters the delay pipe.
  - Otherwise: vram_we<=0, vram_addr holds its previous value.
- Write data pipe:
  - The data popped in cycle N appears on vram_write_data in cycle N+1+ZBT_LAT, i.e. ZBT_LAT cycles after vram_we is seen high.
  - Between writes, vram_write_data holds its last value.
  - Back-to-back writes on consecutive cycles must be supported.
- FIFO rules:
  - Pointers wrap modulo 2^DEPTH_LOG.
  - fifo_level increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
  - Push when full is accepted only if a pop occurs in the same cycle (pop-before-push). Otherwise the entry is dropped, overflow<=1, and fifo_level stays at 2^DEPTH_LOG.
  - Pop when empty never occurs; vram_we stays 0.
  - When empty, simultaneous push and rd_req=0 does not write the new entry in the same cycle. The entry is written at the earliest on the next free cycle (no fall-through).
- Frame start (hcount==0 && vcount==0): overflow<=0 on that cycle, unless a drop occurs in the same cycle, in which case overflow<=1. The FIFO is not flushed.
- Order: writes leave in capture order. Addresses are not modified or deduplicated.

Optional Feature:
- Macro: PROC_ZBT_WRITER_STATS_EN.
- Defined: adds output pairs_written [19:0], the count of vram_we cycles in the previous frame.
  - The internal counter increments per write.
  - At frame start the count is copied to pairs_written and the counter is reset to 0. A write in the frame-start cycle counts toward the new frame.
  - Reset clears both the counter and pairs_written.
- Undefined: no port, no counter logic.

Test Plan:
- Reset mid-frame with 5 entries buffered -> next cycle fifo_level=0, vram_we=0, overflow=0; no further writes until a new capture.
- rd_req=0, single capture at hcount=4 (addr 0x00102, data 0x123456789) -> vram_we=1 with vram_addr=0x00102 at cycle+1; vram_write_data=0x123456789 at cycle+1+ZBT_LAT.
- rd_req held 1 for 20 cycles across 10 qualifying hcounts -> 8 entries buffered, 2 dropped, overflow=1, fifo_level=8. After rd_req drops: 8 consecutive writes in capture order, then overflow clears at the next hcount=0,vcount=0.
- FIFO full, rd_req=0, capture on the same cycle -> pop+push both accepted, fifo_level stays 8, overflow stays 0.
- Alternating rd_req (odd cycles high) across a full active line -> 512 writes, fifo_level never exceeds 1, all addresses match proc_pix_addr in order.
- STATS_EN defined: one frame with 512×768 captures and no drops -> pairs_written=393216 after frame start.
